// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, 48-bit word slicing, tail marker, decoder states.
package noc_pkg;

  localparam int unsigned FLIT_W = 16;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned WORD_W = 3 * FLIT_W;

  // Word slice offsets for {TF, BF, HF}
  localparam int unsigned HF_LSB = 0;
  localparam int unsigned BF_LSB = FLIT_W;
  localparam int unsigned TF_LSB = 2 * FLIT_W;

  // Head flit field positions
  localparam int unsigned HF_SRC_MSB = 15;
  localparam int unsigned HF_SRC_LSB = 8;
  localparam int unsigned HF_DST_MSB = 7;
  localparam int unsigned HF_DST_LSB = 0;

  localparam logic [FLIT_W-1:0] TAIL_MARKER_DEF = 16'hFFFF;

  // Decoder state encodings, kept as plain constants for legacy users
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    READ  = S_READ,
    WAIT  = S_WAIT,
    CHECK = S_CHECK,
    OUT   = S_OUT
  } state_e;

  function automatic logic [ADDR_W-1:0] hf_src(input logic [WORD_W-1:0] w);
    return w[HF_LSB + HF_SRC_LSB +: (HF_SRC_MSB - HF_SRC_LSB + 1)];
  endfunction

  function automatic logic [ADDR_W-1:0] hf_dst(input logic [WORD_W-1:0] w);
    return w[HF_LSB + HF_DST_LSB +: (HF_DST_MSB - HF_DST_LSB + 1)];
  endfunction

  function automatic logic [FLIT_W-1:0] word_bf(input logic [WORD_W-1:0] w);
    return w[BF_LSB +: FLIT_W];
  endfunction

  function automatic logic [FLIT_W-1:0] word_tf(input logic [WORD_W-1:0] w);
    return w[TF_LSB +: FLIT_W];
  endfunction

endpackage

// File: rtl/depacketizer_if.sv
// FIFO read side and payload output handshake of the depacketizer.
interface depacketizer_if;
  import noc_pkg::*;

  logic [WORD_W-1:0] fifo_dout;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_src;
  logic [FLIT_W-1:0] out_data;

  // Depacketizer side
  modport slave (
    input  fifo_dout, fifo_empty, out_ready,
    output fifo_rd_en, out_valid, out_src, out_data
  );

  // Environment side (FIFO + consumer)
  modport master (
    output fifo_dout, fifo_empty, out_ready,
    input  fifo_rd_en, out_valid, out_src, out_data
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Increment unless already at all-ones
  always_ff @(posedge clk) begin
    if (reset)                          count <= '0;
    else if (inc && (count != {W{1'b1}})) count <= count + W'(1);
  end

endmodule

// File: rtl/depacketizer.sv
// Pops one {TF,BF,HF} word per packet, checks tail and destination, and
// presents accepted payloads on a valid/ready port; bad packets are counted.
module depacketizer
  import noc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] NODE_ID     = 8'h00,
  parameter logic [FLIT_W-1:0] TAIL_MARKER = TAIL_MARKER_DEF,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  depacketizer_if.slave    bus,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  state_e            r_state;
  state_e            w_next;
  logic [WORD_W-1:0] r_pkt;
  logic              r_rd_en;
  logic              r_valid;
  logic              r_busy;
  logic [ADDR_W-1:0] r_src;
  logic [FLIT_W-1:0] r_data;
  logic              w_tail_ok;
  logic              w_dst_ok;
  logic              w_inc_pkt;
  logic              w_inc_drop;
  logic              w_inc_err;

  assign w_tail_ok = (word_tf(r_pkt) == TAIL_MARKER);
  assign w_dst_ok  = (hf_dst(r_pkt) == NODE_ID);

  // Next-state and classification; tail check takes priority over dest
  always_comb begin
    w_next     = r_state;
    w_inc_pkt  = 1'b0;
    w_inc_drop = 1'b0;
    w_inc_err  = 1'b0;
    case (r_state)
      IDLE:  if (!bus.fifo_empty) w_next = READ;
      READ:  w_next = WAIT;
      WAIT:  w_next = CHECK;
      CHECK: begin
        if (!w_tail_ok) begin
          w_inc_err = 1'b1;
          w_next    = IDLE;
        end else if (!w_dst_ok) begin
          w_inc_drop = 1'b1;
          w_next     = IDLE;
        end else begin
          w_inc_pkt = 1'b1;
          w_next    = OUT;
        end
      end
      OUT:     if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Word capture, payload load and state-decoded outputs registered from next state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pkt   <= '0;
      r_src   <= '0;
      r_data  <= '0;
      r_rd_en <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      if (r_state == WAIT) r_pkt <= bus.fifo_dout;
      if (w_inc_pkt) begin
        r_src  <= hf_src(r_pkt);
        r_data <= word_bf(r_pkt);
      end
      r_rd_en <= (w_next == READ);
      r_valid <= (w_next == OUT);
      r_busy  <= (w_next != IDLE);
    end
  end

  assign bus.fifo_rd_en = r_rd_en;
  assign bus.out_valid  = r_valid;
  assign bus.out_src    = r_src;
  assign bus.out_data   = r_data;
  assign busy           = r_busy;

  sat_counter #(.W(CNT_W)) u_pkt_cnt  (.clk(clk), .reset(reset), .inc(w_inc_pkt),  .count(pkt_cnt));
  sat_counter #(.W(CNT_W)) u_drop_cnt (.clk(clk), .reset(reset), .inc(w_inc_drop), .count(drop_cnt));
  sat_counter #(.W(CNT_W)) u_err_cnt  (.clk(clk), .reset(reset), .inc(w_inc_err),  .count(err_cnt));

endmodule

// File: tb/tb_depacketizer.sv
// Directed bench for depacketizer: FIFO model, backpressure, error/drop paths,
// back-to-back throughput, mid-packet reset, counter saturation.
module tb_depacketizer;
  import noc_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  depacketizer_if bus ();
  depacketizer_if bus2 ();

  logic        busy, busy2;
  logic [15:0] pkt_cnt, drop_cnt, err_cnt;
  logic [1:0]  pkt2, drop2, err2;
  logic        empty2;

  int checks = 0;
  int errors = 0;

  depacketizer #(.NODE_ID(8'h05), .TAIL_MARKER(16'hFFFF), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .err_cnt(err_cnt)
  );

  // Narrow-counter instance fed a stream of bad-tail words to reach saturation quickly
  depacketizer #(.NODE_ID(8'h05), .TAIL_MARKER(16'hFFFF), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .bus(bus2), .busy(busy2),
    .pkt_cnt(pkt2), .drop_cnt(drop2), .err_cnt(err2)
  );

  assign bus2.fifo_dout  = 48'hFFFE_AAAA_3706;
  assign bus2.fifo_empty = empty2;
  assign bus2.out_ready  = 1'b1;

  // FIFO model: write side owned by the stimulus, read side by this process
  logic [47:0] mem [0:15];
  logic [3:0]  wr_ptr = 4'd0;
  logic [3:0]  rd_ptr = 4'd0;
  assign bus.fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      bus.fifo_dout <= mem[rd_ptr];
      rd_ptr        <= rd_ptr + 4'd1;
    end
  end

  task automatic push(input logic [47:0] w);
    mem[wr_ptr] = w;
    wr_ptr      = wr_ptr + 4'd1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.out_ready = 1'b1;
    empty2        = 1'b1;
    reset         = 1'b1;
    tick();
    tick();
    // Reset values
    check("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_src",   64'(bus.out_src), 64'd0);
    check("rst_data",  64'(bus.out_data), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_cnts",  {16'd0, pkt_cnt, drop_cnt, err_cnt}, 64'd0);
    reset = 1'b0;
    tick();

    // Good packet, consumer ready: latency 1/4
    push(48'hFFFF_1234_3705);
    tick();
    check("t1_rd_en_c1", 64'(bus.fifo_rd_en), 64'd1);
    check("t1_busy_c1",  64'(busy), 64'd1);
    tick();
    check("t1_rd_en_c2", 64'(bus.fifo_rd_en), 64'd0);
    tick();
    check("t1_valid_c3", 64'(bus.out_valid), 64'd0);
    tick();
    check("t1_valid_c4", 64'(bus.out_valid), 64'd1);
    check("t1_src",      64'(bus.out_src), 64'h37);
    check("t1_data",     64'(bus.out_data), 64'h1234);
    check("t1_pkt_cnt",  64'(pkt_cnt), 64'd1);
    tick();
    check("t1_valid_c5", 64'(bus.out_valid), 64'd0);
    check("t1_busy_c5",  64'(busy), 64'd0);

    // Backpressure: a queued bad-tail packet must not be read while held
    bus.out_ready = 1'b0;
    push(48'hFFFF_BEEF_3705);
    tick(); tick(); tick(); tick();
    check("t2_valid", 64'(bus.out_valid), 64'd1);
    check("t2_pkt_cnt", 64'(pkt_cnt), 64'd2);
    push(48'hFFFE_AAAA_3706);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t2_hold_valid", 64'(bus.out_valid), 64'd1);
      check("t2_hold_data",  {bus.out_src, bus.out_data}, 64'h37_BEEF);
      check("t2_hold_rd_en", 64'(bus.fifo_rd_en), 64'd0);
      check("t2_hold_busy",  64'(busy), 64'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    check("t2_release_valid", 64'(bus.out_valid), 64'd0);
    check("t2_release_busy",  64'(busy), 64'd0);

    // Errored packet drains: read one cycle after IDLE, never any output
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_rd_en",  64'(bus.fifo_rd_en), 64'(i == 0));
      check("t3_valid",  64'(bus.out_valid), 64'd0);
    end
    check("t3_err_cnt",  64'(err_cnt), 64'd1);
    check("t3_drop_cnt", 64'(drop_cnt), 64'd0);
    check("t3_pkt_cnt",  64'(pkt_cnt), 64'd2);

    // Good tail, wrong destination
    push(48'hFFFF_AAAA_3706);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_valid", 64'(bus.out_valid), 64'd0);
    end
    check("t4_drop_cnt", 64'(drop_cnt), 64'd1);
    check("t4_err_cnt",  64'(err_cnt), 64'd1);

    // Three back-to-back good packets: reads every 5 cycles
    push(48'hFFFF_0001_1105);
    push(48'hFFFF_0002_2205);
    push(48'hFFFF_0003_3305);
    for (int c = 1; c <= 16; c++) begin
      tick();
      check("t5_rd_en", 64'(bus.fifo_rd_en), 64'(c == 1 || c == 6 || c == 11));
      check("t5_valid", 64'(bus.out_valid), 64'(c == 4 || c == 9 || c == 14));
      if (c == 4)  check("t5_out0", {bus.out_src, bus.out_data}, 64'h11_0001);
      if (c == 9)  check("t5_out1", {bus.out_src, bus.out_data}, 64'h22_0002);
      if (c == 14) check("t5_out2", {bus.out_src, bus.out_data}, 64'h33_0003);
    end
    check("t5_pkt_cnt", 64'(pkt_cnt), 64'd5);

    // Reset while in WAIT: the popped word is lost and not counted
    push(48'hFFFF_5A5A_4205);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("t6_rst_outs", {bus.fifo_rd_en, bus.out_valid, busy, bus.out_src, bus.out_data}, 64'd0);
    check("t6_rst_cnts", {16'd0, pkt_cnt, drop_cnt, err_cnt}, 64'd0);
    reset = 1'b0;
    tick();
    push(48'hFFFF_C3C3_9905);
    tick(); tick(); tick(); tick();
    check("t6_valid", 64'(bus.out_valid), 64'd1);
    check("t6_out",   {bus.out_src, bus.out_data}, 64'h99_C3C3);
    check("t6_cnts",  {16'd0, pkt_cnt, drop_cnt, err_cnt}, {16'd0, 16'd1, 16'd0, 16'd0});
    tick();

    // Saturation on the 2-bit instance: errored packet every 4 cycles
    empty2 = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      tick();
      if (c == 10) check("t7_err_cnt_c10", 64'(err2), 64'd2);
      if (c == 14) check("t7_err_cnt_c14", 64'(err2), 64'd3);
      if (c == 19) check("t7_err_cnt_c19", 64'(err2), 64'd3);
    end
    check("t7_other_cnts", {pkt2, drop2}, 64'd0);
    empty2 = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/depacketizer.md
# depacketizer

Receive-side counterpart of the node packetizer. Pops one 48-bit packed flit word {TF, BF, HF} at a time from the router-to-node FIFO, validates the tail marker and destination address, and hands the accepted body payload with its source address to the local consumer over a valid/ready port. Malformed or misrouted packets are discarded and counted.

## Interface
Parameters:
- NODE_ID, 8'h00, this node's address; compared against HF[7:0]
- TAIL_MARKER, 16'hFFFF, required TF value
- CNT_W, 16, width of the statistics counters

Ports:
- clk  in  1  main clock
- reset  in  1  synchronous, active-high reset
- fifo_dout  in  48  FIFO read data {TF[47:32], BF[31:16], HF[15:0]}; valid the cycle after fifo_rd_en
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_en  out  1  FIFO pop strobe, one cycle per packet
- out_valid  out  1  payload available
- out_ready  in  1  consumer accepts payload
- out_src  out  8  source address, HF[15:8]
- out_data  out  16  body flit, BF
- busy  out  1  high in every state except IDLE
- pkt_cnt  out  CNT_W  accepted packets
- drop_cnt  out  CNT_W  packets with good tail but HF[7:0] != NODE_ID
- err_cnt  out  CNT_W  packets with TF != TAIL_MARKER

## Operation
- Head flit format: HF[15:8] = src, HF[7:0] = dest. Body = 16-bit payload. Tail = TAIL_MARKER.
- FSM, all outputs registered or Moore-decoded:
  - IDLE: if fifo_empty == 0 -> READ; else stay.
  - READ: fifo_rd_en = 1 (exactly one cycle) -> WAIT.
  - WAIT: fifo_dout is valid; capture it into pkt_reg -> CHECK.
  - CHECK: classify pkt_reg. TF != TAIL_MARKER -> err_cnt++, -> IDLE. Otherwise, if dest != NODE_ID -> drop_cnt++, -> IDLE. Otherwise load out_src/out_data, pkt_cnt++, -> OUT.
  - OUT: out_valid = 1, with out_src/out_data held stable; on out_ready == 1 -> IDLE.
- Tail check has priority: a packet with a bad tail and a wrong dest increments only err_cnt.
- Counters saturate at all-ones; no wrap.
- fifo_empty is sampled only in IDLE. The block never issues fifo_rd_en while fifo_empty is high.
- pkt_cnt counts on acceptance in CHECK, not on the out_ready handshake.

## Timing
- Reset values: fifo_rd_en = 0, out_valid = 0, out_src = 0, out_data = 0, busy = 0, all counters = 0, state = IDLE, pkt_reg = 0.
- Reset mid-operation: at the next edge, return to IDLE with all outputs at reset values. A word popped but not yet classified is lost and is not counted.
- Latency, with IDLE and !fifo_empty at cycle 0:
  - cycle 1: fifo_rd_en = 1
  - cycle 2: capture
  - cycle 3: classify and counter update
  - cycle 4: out_valid = 1 (earliest)
- Throughput: at most one packet per 5 cycles with out_ready held high, or per 4 cycles for dropped/errored packets (CHECK -> IDLE).
- Backpressure: out_valid stays high and the data is frozen indefinitely while out_ready = 0. No FIFO reads occur meanwhile.
- out_ready asserted outside OUT is ignored.

## Structure
- Shared package noc_pkg holds:
  - flit field positions (HF_SRC_MSB/LSB, HF_DST_MSB/LSB)
  - word slice offsets for HF/BF/TF within the 48-bit word
  - default TAIL_MARKER
  - state enum (IDLE, READ, WAIT, CHECK, OUT)
- The packetizer uses the same package so encode and decode agree.
- One sub-module: sat_counter (parameter W; inputs clk, reset, inc; output count), instantiated three times.

## Test plan
- NODE_ID=8'h05. FIFO holds {16'hFFFF, 16'h1234, 16'h3705}, out_ready = 1 -> fifo_rd_en pulses once at cycle 1; out_valid at cycle 4 with out_src = 8'h37, out_data = 16'h1234; pkt_cnt = 1.
- Same packet with out_ready = 0 for 10 cycles -> out_valid and data stay constant, no further fifo_rd_en, busy = 1. Raising out_ready completes the transfer and returns to IDLE next cycle.
- {16'hFFFE, 16'hAAAA, 16'h3706} -> err_cnt = 1, drop_cnt = 0, out_valid never asserted.
- {16'hFFFF, 16'hAAAA, 16'h3706} -> drop_cnt = 1, no output.
- Three back-to-back good packets with fifo_empty low throughout -> fifo_rd_en pulses spaced 5 cycles apart, pkt_cnt = 3.
- Reset asserted during WAIT -> next cycle all outputs and counters are 0. A subsequent good packet decodes normally.
- Force counter to all-ones minus 1, send two errored packets -> err_cnt holds at all-ones.
